// File: rtl/key_event_gen.sv
// Button front end: two-flop synchronisers, per-key debounce FSMs with one-cycle press events, and a switch-bank snapshot on select.
// Optional KEY_EVT_AUTOREPEAT_EN re-fires press events every REPEAT_CYCLES while a key stays pressed.
module key_event_gen #(
    parameter int NKEYS           = 2,
    parameter int SW_W            = 9,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic             MAX10_CLK1_50,
    input  logic             rst,
    input  logic [NKEYS-1:0] KEY,
    input  logic [SW_W-1:0]  SW,
    output logic [NKEYS-1:0] press_pulse,
    output logic [NKEYS-1:0] held,
    output logic             move_strobe,
    output logic [3:0]       move_idx,
    output logic             move_valid
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ONES_W = $clog2(SW_W + 1);
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DB_DN   = 2'd1,
        PRESSED = 2'd2,
        DB_UP   = 2'd3
    } key_state_t;

    logic [NKEYS-1:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic [SW_W-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    key_state_t       state_q [NKEYS];
    key_state_t       state_d [NKEYS];
    logic [CNT_W-1:0] cnt_q [NKEYS];
    logic [CNT_W-1:0] cnt_d [NKEYS];
    logic [NKEYS-1:0] pulse_q, pulse_d;
    logic [NKEYS-1:0] held_q, held_d;
    logic             strobe_q, strobe_d;
    logic [3:0]       idx_q, idx_d;
    logic             valid_q, valid_d;
    logic [ONES_W-1:0] ones;
    logic [3:0]       one_pos;

`ifdef KEY_EVT_AUTOREPEAT_EN
    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0] rpt_q [NKEYS];
    logic [RPT_W-1:0] rpt_d [NKEYS];
`endif

    always_comb begin
        key_s1_d = KEY;
        key_s2_d = key_s1_q;
        sw_s1_d  = SW;
        sw_s2_d  = sw_s1_q;
        pulse_d  = '0;
        held_d   = '0;
        for (int k = 0; k < NKEYS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
`ifdef KEY_EVT_AUTOREPEAT_EN
            rpt_d[k]   = '0;
`endif
            case (state_q[k])
                IDLE: begin
                    if (!key_s2_q[k]) begin
                        state_d[k] = DB_DN;
                        cnt_d[k]   = CNT_ONE;
                    end
                end
                DB_DN: begin
                    if (key_s2_q[k]) begin
                        state_d[k] = IDLE;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == DB_MAX) begin
                        state_d[k] = PRESSED;
                        cnt_d[k]   = '0;
                        pulse_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (key_s2_q[k]) begin
                        state_d[k] = DB_UP;
                        cnt_d[k]   = CNT_ONE;
                    end
`ifdef KEY_EVT_AUTOREPEAT_EN
                    else if (rpt_q[k] == RPT_MAX) begin
                        pulse_d[k] = 1'b1;
                    end else begin
                        rpt_d[k] = rpt_q[k] + RPT_W'(1);
                    end
`endif
                end
                default: begin
                    if (!key_s2_q[k]) begin
                        state_d[k] = PRESSED;
                        cnt_d[k]   = '0;
                    end else if (cnt_q[k] == DB_MAX) begin
                        state_d[k] = IDLE;
                        cnt_d[k]   = '0;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
            endcase
            held_d[k] = (state_d[k] == PRESSED) || (state_d[k] == DB_UP);
        end

        // Snapshot uses the same synchronised sample the select FSM saw.
        ones    = '0;
        one_pos = '0;
        for (int i = 0; i < SW_W; i++) begin
            if (sw_s2_q[i]) begin
                ones    = ones + ONES_W'(1);
                one_pos = 4'(i);
            end
        end
        strobe_d = pulse_d[0];
        idx_d    = idx_q;
        valid_d  = valid_q;
        if (pulse_d[0]) begin
            valid_d = (ones == ONES_W'(1));
            idx_d   = valid_d ? one_pos : 4'd0;
        end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            key_s1_q <= '1;
            key_s2_q <= '1;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            pulse_q  <= '0;
            held_q   <= '1;
            strobe_q <= 1'b0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            for (int k = 0; k < NKEYS; k++) begin
                state_q[k] <= PRESSED;
                cnt_q[k]   <= '0;
`ifdef KEY_EVT_AUTOREPEAT_EN
                rpt_q[k]   <= '0;
`endif
            end
        end else begin
            key_s1_q <= key_s1_d;
            key_s2_q <= key_s2_d;
            sw_s1_q  <= sw_s1_d;
            sw_s2_q  <= sw_s2_d;
            pulse_q  <= pulse_d;
            held_q   <= held_d;
            strobe_q <= strobe_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            for (int k = 0; k < NKEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
`ifdef KEY_EVT_AUTOREPEAT_EN
                rpt_q[k]   <= rpt_d[k];
`endif
            end
        end
    end

    assign press_pulse = pulse_q;
    assign held        = held_q;
    assign move_strobe = strobe_q;
    assign move_idx    = idx_q;
    assign move_valid  = valid_q;

endmodule
